// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - state encoding, default parameters and sizing helper for mem_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE  = 2'd0,
        MEM_ARB_GNT_I = 2'd1,
        MEM_ARB_GNT_D = 2'd2,
        MEM_ARB_RESP  = 2'd3
    } mem_arb_state_e;

    localparam int unsigned MEM_ARB_STARVE_LIMIT = 4;
    localparam int unsigned MEM_ARB_TIMEOUT      = 255;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - load-on-grant down-counter that flags a memory access hung for TIMEOUT cycles
module mem_arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = MEM_ARB_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = cnt_width(TIMEOUT - 1);
            localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt;
            logic          running;

            // The first granted cycle counts as one, so expire lands in cycle TIMEOUT.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt     <= '0;
                    running <= 1'b0;
                end else if (load) begin
                    cnt     <= LOAD_VAL;
                    running <= 1'b1;
                end else if (clear || expire) begin
                    cnt     <= '0;
                    running <= 1'b0;
                end else if (running) begin
                    cnt <= cnt - CW'(1);
                end
            end

            assign expire = running && (cnt == '0);
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one variable-latency memory port between fetch and data requesters
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = MEM_ARB_STARVE_LIMIT,
    parameter int unsigned TIMEOUT      = MEM_ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              bus_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack
);

    localparam int unsigned SW = cnt_width(STARVE_LIMIT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    mem_arb_state_e state, state_nxt;
    logic [SW-1:0]  streak;
    logic           gnt_d;
    logic           err;
    logic           grant;
    logic           in_gnt;
    logic           resolve;
    logic           expire;

    assign in_gnt  = (state == MEM_ARB_GNT_I) || (state == MEM_ARB_GNT_D);
    assign resolve = in_gnt && (m_ack || expire);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            MEM_ARB_IDLE: begin
                // Data belongs to the older instruction and wins unless fetch has waited too long.
                if (d_req && !(i_req && streak == STREAK_MAX)) begin
                    state_nxt = MEM_ARB_GNT_D;
                    grant     = 1'b1;
                end else if (i_req) begin
                    state_nxt = MEM_ARB_GNT_I;
                    grant     = 1'b1;
                end
            end
            MEM_ARB_GNT_I, MEM_ARB_GNT_D: begin
                if (resolve) state_nxt = MEM_ARB_RESP;
            end
            MEM_ARB_RESP: state_nxt = MEM_ARB_IDLE;
            default:      state_nxt = MEM_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= MEM_ARB_IDLE;
            streak  <= '0;
            gnt_d   <= 1'b0;
            err     <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == MEM_ARB_IDLE) begin
                if (state_nxt == MEM_ARB_GNT_D && i_req)
                    streak <= (streak == STREAK_MAX) ? streak : streak + SW'(1);
                else
                    streak <= '0;
                if (grant) begin
                    gnt_d <= (state_nxt == MEM_ARB_GNT_D);
                    err   <= 1'b0;
                end
            end
            // An ack arriving in the expiry cycle still completes the access normally.
            if (resolve) begin
                err <= !m_ack;
                if (state == MEM_ARB_GNT_D)
                    d_rdata <= m_ack ? m_rdata : '0;
                else
                    i_rdata <= m_ack ? m_rdata : '0;
            end
        end
    end

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (grant),
        .clear  (in_gnt && m_ack),
        .expire (expire)
    );

    assign m_req   = in_gnt;
    assign m_we    = (state == MEM_ARB_GNT_D) && d_we;
    assign m_addr  = (state == MEM_ARB_GNT_D) ? d_addr :
                     (state == MEM_ARB_GNT_I) ? i_addr : '0;
    assign m_wdata = (state == MEM_ARB_GNT_D) ? d_wdata : '0;
    assign i_ready = (state == MEM_ARB_RESP) && !gnt_d;
    assign d_ready = (state == MEM_ARB_RESP) && gnt_d;
    assign bus_err = (state == MEM_ARB_RESP) && err;

endmodule
